// File: rtl/data_mem_resp.sv
// data_mem_resp: 64 x 32-bit little-endian data memory with a combinational load path,
// sticky error flags, a saturating store counter and a mailbox-driven PASS/FAIL status FSM.
module data_mem_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    input  logic [1:0]  size,
    input  logic        unsign,
    output logic [31:0] readdata,
    output logic        done,
    output logic        pass,
    output logic        misalign_err,
    output logic        oob_err,
    output logic [15:0] wr_count
);
    localparam logic [31:0] MBOX_ADDR = 32'd56;
    localparam logic [31:0] SIGNATURE = 32'h000F_0000;

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_mem [64];
    logic [15:0] r_wr_count;
    logic        r_done;
    logic        r_pass;
    logic        r_misalign_err;
    logic        r_oob_err;

    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misalign;
    logic        w_oob;
    logic        w_store;
    logic        w_commit;
    logic        w_mbox_hit;
    logic [5:0]  w_index;
    logic [31:0] w_word;
    logic [31:0] w_wmask;
    logic [31:0] w_wdata;
    logic [31:0] w_word_nxt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_index    = addr[7:2];
    assign w_word     = r_mem[w_index];
    assign w_is_byte  = (size == 2'b10);
    assign w_is_half  = (size == 2'b01);
    assign w_is_word  = !w_is_byte && !w_is_half;
    assign w_misalign = (w_is_word && (addr[1:0] != 2'b00)) || (w_is_half && addr[0]);
    assign w_oob      = (addr[31:8] != 24'd0);
    // An unknown memwrite never resolves true in the if-conditions below, so it cannot store.
    assign w_store    = (memwrite == 1'b1) && !rst;
    assign w_commit   = w_store && !w_misalign && !w_oob;
    assign w_mbox_hit = w_commit && w_is_word && (addr == MBOX_ADDR);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_byte = w_word[7:0];
        case (addr[1:0])
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            2'b11:   w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
        w_half   = addr[1] ? w_word[31:16] : w_word[15:0];
        readdata = w_word;
        if (w_misalign || w_oob) begin
            readdata = '0;
        end else if (w_is_byte) begin
            readdata = {{24{!unsign && w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            readdata = {{16{!unsign && w_half[15]}}, w_half};
        end
    end

    always_comb begin
        w_wmask = '1;
        w_wdata = writedata;
        if (w_is_byte) begin
            w_wdata = {4{writedata[7:0]}};
            case (addr[1:0])
                2'b01:   w_wmask = 32'h0000_FF00;
                2'b10:   w_wmask = 32'h00FF_0000;
                2'b11:   w_wmask = 32'hFF00_0000;
                default: w_wmask = 32'h0000_00FF;
            endcase
        end else if (w_is_half) begin
            w_wdata = {2{writedata[15:0]}};
            w_wmask = addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        end
        w_word_nxt = (w_word & ~w_wmask) | (w_wdata & w_wmask);
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == ST_RUN) && w_mbox_hit) begin
            w_state_nxt = (writedata == SIGNATURE) ? ST_PASS : ST_FAIL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_state_nxt != ST_RUN);
            r_pass  <= (w_state_nxt == ST_PASS);
        end
    end

    // NOTE: the array is built from flops so reset can clear every word in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) r_mem[i] <= '0;
            r_wr_count     <= '0;
            r_misalign_err <= 1'b0;
            r_oob_err      <= 1'b0;
        end else begin
            if (w_commit) r_mem[w_index] <= w_word_nxt;
            if (w_commit && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 16'd1;
            if (w_store && w_misalign) r_misalign_err <= 1'b1;
            if (w_store && w_oob) r_oob_err <= 1'b1;
        end
    end

    assign done         = r_done;
    assign pass         = r_pass;
    assign misalign_err = r_misalign_err;
    assign oob_err      = r_oob_err;
    assign wr_count     = r_wr_count;

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have a single clock domain on `clk`, with a synchronous, active-high reset `rst`.
REQ-002 SHALL provide these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- memwrite  in  1  store request this cycle
- addr  in  32  byte address (CPU ALU result)
- writedata  in  32  store data, right-aligned
- size  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word)
- unsign  in  1  load extension: 1 zero-extend, 0 sign-extend
- readdata  out  32  load data, combinational
- done  out  1  mailbox has been written (sticky)
- pass  out  1  mailbox value matched the signature (sticky)
- misalign_err  out  1  sticky: misaligned access seen
- oob_err  out  1  sticky: out-of-range access seen
- wr_count  out  16  committed store count

Function
REQ-003 SHALL hold 64 x 32-bit words, indexed by addr[7:2]; the valid byte range is 0..255.
REQ-004 SHALL use little-endian byte lanes: addr[1:0]=0 selects bits 7:0 and 3 selects bits 31:24; a halfword at addr[1]=0 selects bits 15:0.
REQ-005 SHALL produce readdata combinationally, in the same cycle: the word, or the selected byte/half extended to 32 bits per `unsign`.
REQ-006 SHALL commit a store at the rising edge when memwrite=1, rst=0, the access is aligned and addr<256; only the addressed lanes change.
REQ-007 SHALL write writedata[7:0] on a byte store, writedata[15:0] on a half store and all 32 bits on a word store, into the lanes selected by REQ-004.
REQ-008 SHALL define misalignment as: a word access with addr[1:0]!=0, or a half access with addr[0]=1.
REQ-009 SHALL, on a misaligned store, suppress the write and set misalign_err at the next edge.
REQ-010 SHALL, on a misaligned load (memwrite=0), return readdata=0; no flag is set for loads.
REQ-011 SHALL, on a store with addr>=256, suppress the write and set oob_err; a load with addr>=256 returns readdata=0.
REQ-012 SHALL increment wr_count by 1 per committed store, saturating at 16'hFFFF; suppressed stores do not count.
REQ-013 SHALL implement a status FSM with states RUN, PASS, FAIL; RUN is entered on reset.
REQ-014 SHALL make the transition RUN->PASS on a committed word store to addr=56 with writedata=32'h000F0000, and RUN->FAIL on a committed word store to addr=56 with any other value.
REQ-015 SHALL treat a byte or half store to addresses 56..59 as an ordinary store: memory updates, no FSM transition.
REQ-016 SHALL keep PASS and FAIL absorbing until reset; later mailbox stores still update memory but not the state.
REQ-017 SHALL drive done=1 in PASS or FAIL and pass=1 only in PASS, both as registered outputs changing at the edge that commits the mailbox store.
REQ-018 SHALL resolve a store and a load to the same address in the same cycle as follows: readdata shows the pre-store contents; the new data is visible from the next cycle.
REQ-019 SHALL treat a store with any X/Z on memwrite as no store.

Reset
REQ-020 SHALL, at any edge with rst=1, clear all 64 words to 0, enter RUN, and clear done, pass, misalign_err, oob_err and wr_count, all within one cycle.
REQ-021 SHALL give rst priority over a simultaneous memwrite: no write commits and no FSM transition occurs.
REQ-022 SHALL make readdata reflect cleared memory (0) in the cycle after the reset edge.

Verification
REQ-023 Word store 0x12345678 @8, then loads @8 -> bench SHALL see:
- word: 0x12345678
- byte @9, unsign=0: 0x00000056
- byte @11, unsign=0: 0x00000012
- half @10, unsign=1: 0x00001234
REQ-024 Byte store 0x80 @4 onto 0, then loads @4 -> bench SHALL see:
- word: 0x00000080
- byte, unsign=0: 0xFFFFFF80
- byte, unsign=1: 0x00000080
REQ-025 Misaligned/out-of-range stores -> bench SHALL see:
- word store @6: memory unchanged, misalign_err=1, wr_count unchanged
- store @300: oob_err=1, wr_count unchanged
REQ-026 Mailbox -> bench SHALL see:
- word store 0x000F0000 @56: done=1, pass=1 after that edge
- then word store 0 @56: pass stays 1
- fresh run, word store 0x1 @56: done=1, pass=0
REQ-027 rst asserted during a memwrite to @56 with the signature -> after the edge: done=0, word @56 reads 0, wr_count=0.
REQ-028 65538 committed stores -> wr_count=16'hFFFF.
